// File: rtl/genius_seq_player.sv
// rtl/genius_seq_player.sv - Genius colour-sequence playback engine
//
// Replays a latched 16 x 4-bit colour sequence on the LEDs, one symbol per
// ON dwell followed by a blank OFF dwell, then pulses done.
//
// Parameters:
//   ON_CYCLES  - cycles each symbol is lit (>= 1)
//   OFF_CYCLES - blank cycles after each symbol (>= 1)
//   CNT_W      - dwell counter width, holds max(ON_CYCLES, OFF_CYCLES)-1
//
// Ports:
//   clk       in   system clock
//   R         in   synchronous active-high reset
//   start     in   begin playback (sampled only in IDLE)
//   abort     in   stop playback at once, no done
//   round_len in   symbols to play, 0..16 (larger values clamp to 16)
//   seq       in   packed sequence, symbol i = seq[4i+3:4i]
//   led       out  current symbol while ON, zero otherwise
//   busy      out  high in LOAD/ON/OFF
//   done      out  one-cycle pulse on normal completion
//   idx       out  index of the symbol being played, 0 when idle

module genius_seq_player #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int CNT_W      = 25
) (
    input  logic        clk,
    input  logic        R,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  round_len,
    input  logic [63:0] seq,
    output logic [3:0]  led,
    output logic        busy,
    output logic        done,
    output logic [3:0]  idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_idx;
    logic [63:0]       r_seq_q;
    logic [4:0]        r_len_q;

    state_t            w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [3:0]        w_idx;
    logic [63:0]       w_seq_q;
    logic [4:0]        w_len_q;

    logic [4:0]        w_len_clamp;
    logic              w_last_sym;

    assign w_len_clamp = (round_len > 5'd16) ? 5'd16 : round_len;
    // len_q is nonzero whenever OFF is reachable, so len_q-1 never underflows there
    assign w_last_sym  = ({1'b0, r_idx} == (r_len_q - 5'd1));

    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_seq_q <= '0;
            r_len_q <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_seq_q <= w_seq_q;
            r_len_q <= w_len_q;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_seq_q = r_seq_q;
        w_len_q = r_len_q;

        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                w_idx = '0;
                // start outranks abort here: abort means nothing in IDLE
                if (start) begin
                    w_state = S_LOAD;
                    w_seq_q = seq;
                    w_len_q = w_len_clamp;
                end
            end
            S_LOAD: begin
                w_cnt = '0;
                w_idx = '0;
                if (abort) begin
                    w_state = S_IDLE;
                end else if (r_len_q == 5'd0) begin
                    w_state = S_DONE;
                end else begin
                    w_state = S_ON;
                end
            end
            S_ON: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_idx   = '0;
                end else if (r_cnt == ON_LAST) begin
                    w_state = S_OFF;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_OFF: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_idx   = '0;
                end else if (r_cnt == OFF_LAST) begin
                    w_cnt = '0;
                    if (w_last_sym) begin
                        w_state = S_DONE;
                    end else begin
                        w_state = S_ON;
                        w_idx   = r_idx + 4'd1;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                // abort is ignored here; the done pulse always completes
                w_state = S_IDLE;
                w_cnt   = '0;
                w_idx   = '0;
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_idx   = '0;
            end
        endcase
    end

    // Outputs are decoded from registered state only
    assign led  = (r_state == S_ON) ? r_seq_q[{r_idx, 2'b00} +: 4] : 4'b0000;
    assign busy = (r_state == S_LOAD) || (r_state == S_ON) || (r_state == S_OFF);
    assign done = (r_state == S_DONE);
    assign idx  = r_idx;

endmodule
